unsig_int_to_float: RTL and testbench



---
 rtl/fpu_pkg.sv | 26 ++
 rtl/fp32_round_pack.sv | 46 ++++
 rtl/unsig_int_to_float.sv | 100 ++++++++++
 tb/tb_unsig_int_to_float.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision field widths, the packed float
// layout and the state encoding of the int-to-float converters.
package fpu_pkg;

   localparam int FP32_BIAS  = 127;
   localparam int FP32_EXP_W = 8;
   localparam int FP32_MAN_W = 23;

   // Exponent of an operand whose leading one sits in bit 31.
   localparam logic [8:0] I2F_E_INIT = 9'(31 + FP32_BIAS);

   typedef struct packed {
      logic                  s;
      logic [FP32_EXP_W-1:0] e;
      logic [FP32_MAN_W-1:0] m;
   } fp32_t;

   typedef enum logic [2:0] {
      IDLE,
      NORM,
      ROUND,
      PACK,
      PUT
   } i2f_state_t;

endpackage

// File: rtl/fp32_round_pack.sv
// Rounds a normalised 32-bit magnitude (leading one in bit 31) to 24 bits and
// packs it with its biased exponent into a positive single-precision value.
module fp32_round_pack
   import fpu_pkg::*;
#(
   parameter int ROUND_RNE = 1
) (
   input  logic [8:0]  e,
   input  logic [31:0] m,
   output fp32_t       z
);

   logic [23:0] man24;
   logic        guard;
   logic        rnd;
   logic        sticky;
   logic        inc;
   logic [24:0] sum;
   logic [23:0] man24_rnd;
   logic [8:0]  e_rnd;
   logic        unused_e_msb;

   // NOTE: every variable written here gets a value on every path, so no latch is inferred.
   always_comb begin
      man24  = m[31:8];
      guard  = m[7];
      rnd    = m[6];
      sticky = |m[5:0];
      // Halfway cases go to the even mantissa (m[8] is its lsb).
      inc    = (ROUND_RNE != 0) && guard && (rnd || sticky || m[8]);
      sum    = {1'b0, man24} + {24'd0, inc};
      if (sum[24]) begin
         man24_rnd = 24'h800000;
         e_rnd     = e + 9'd1;
      end else begin
         man24_rnd = sum[23:0];
         e_rnd     = e;
      end
   end

   // The exponent never exceeds 159, so the ninth bit is always clear.
   assign unused_e_msb = e_rnd[8];

   assign z = '{s: 1'b0, e: e_rnd[7:0], m: man24_rnd[22:0]};

endmodule

// File: rtl/unsig_int_to_float.sv
// Multi-cycle 32-bit unsigned integer to IEEE-754 single conversion with an
// iterative one-bit-per-cycle normaliser and strobe/ack handshakes on both sides.
module unsig_int_to_float
   import fpu_pkg::*;
#(
   parameter int ROUND_RNE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] input_a,
   input  logic        input_a_stb,
   output logic        input_a_ack,
   output logic [31:0] output_z,
   output logic        output_z_stb,
   input  logic        output_z_ack
);

   i2f_state_t  state;
   i2f_state_t  next_state;
   logic [31:0] m;
   logic [8:0]  e;
   fp32_t       z;
   fp32_t       rp_z;
   logic        take_a;
   logic        give_z;

   assign take_a = input_a_stb && input_a_ack;
   assign give_z = output_z_stb && output_z_ack;

   fp32_round_pack #(
      .ROUND_RNE (ROUND_RNE)
   ) u_round_pack (
      .e (e),
      .m (m),
      .z (rp_z)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (take_a) next_state = (input_a == 32'd0) ? PUT : NORM;
         NORM:    if (m[31]) next_state = ROUND;
         ROUND:   next_state = PACK;
         PACK:    next_state = PUT;
         PUT:     if (give_z) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: state-holding registers use non-blocking assignments so every
   // register in this block sees the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m            <= '0;
         e            <= '0;
         z            <= '0;
         output_z     <= '0;
         output_z_stb <= 1'b0;
         input_a_ack  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (take_a) begin
                  m           <= input_a;
                  e           <= I2F_E_INIT;
                  input_a_ack <= 1'b0;
                  if (input_a == 32'd0) z <= '0;
               end else begin
                  input_a_ack <= 1'b1;
               end
            end
            NORM: begin
               if (!m[31]) begin
                  m <= m << 1;
                  e <= e - 9'd1;
               end
            end
            ROUND: z <= rp_z;
            // PACK is a pure alignment cycle; the packed word is already in z.
            PACK: ;
            PUT: begin
               if (!output_z_stb) begin
                  output_z     <= z;
                  output_z_stb <= 1'b1;
               end else if (output_z_ack) begin
                  output_z_stb <= 1'b0;
                  input_a_ack  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_unsig_int_to_float.sv
// Directed and random checks of unsig_int_to_float against an independent
// remainder-based rounding model, with an expected-result queue.
module tb_unsig_int_to_float;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] input_a;
   logic        input_a_stb;
   logic        input_a_ack;
   logic [31:0] output_z;
   logic        output_z_stb;
   logic        output_z_ack;

   logic [31:0] t_a;
   logic        t_stb;
   logic        t_ack;
   logic [31:0] t_z;
   logic        t_zstb;
   logic        t_zack;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   unsig_int_to_float #(.ROUND_RNE(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .input_a      (input_a),
      .input_a_stb  (input_a_stb),
      .input_a_ack  (input_a_ack),
      .output_z     (output_z),
      .output_z_stb (output_z_stb),
      .output_z_ack (output_z_ack)
   );

   unsig_int_to_float #(.ROUND_RNE(0)) dut_tz (
      .clk          (clk),
      .rst          (rst),
      .input_a      (t_a),
      .input_a_stb  (t_stb),
      .input_a_ack  (t_ack),
      .output_z     (t_z),
      .output_z_stb (t_zstb),
      .output_z_ack (t_zack)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Round-to-nearest-even by comparing the discarded remainder with one half ulp.
   function automatic logic [31:0] ref_float(input logic [31:0] a);
      int              p;
      int              sh;
      longint unsigned q;
      longint unsigned rem;
      longint unsigned half;
      logic [7:0]      ex;
      if (a == 32'd0) return 32'd0;
      p = 31;
      while (!a[p]) p--;
      q = {32'd0, a};
      if (p <= 23) begin
         q = q << (23 - p);
      end else begin
         sh   = p - 23;
         rem  = q & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         q    = q >> sh;
         if (rem > half || (rem == half && q[0])) q++;
         if (q == (64'd1 << 24)) begin
            q = q >> 1;
            p++;
         end
      end
      ex = 8'(127 + p);
      return {1'b0, ex, q[22:0]};
   endfunction

   task automatic run_op(input logic [31:0] a, input int exp_lat, input int hold, input string tag);
      int          lat;
      int          waitc;
      logic [31:0] held;
      @(negedge clk);
      waitc = 0;
      while (!input_a_ack && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      check({tag, " ready"}, {31'd0, input_a_ack}, 32'd1);
      input_a     = a;
      input_a_stb = 1'b1;
      exp_q.push_back(ref_float(a));
      @(negedge clk);
      input_a_stb = 1'b0;
      check({tag, " busy"}, {31'd0, input_a_ack}, 32'd0);
      lat = 0;
      while (!output_z_stb && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check({tag, " stb"}, {31'd0, output_z_stb}, 32'd1);
      if (exp_lat > 0) check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      held = output_z;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, " hold z"}, output_z, held);
         check({tag, " hold stb/ack"}, {30'd0, output_z_stb, input_a_ack}, 32'd2);
      end
      check({tag, " result"}, output_z, exp_q.pop_front());
      output_z_ack = 1'b1;
      @(negedge clk);
      output_z_ack = 1'b0;
      check({tag, " release"}, {30'd0, output_z_stb, input_a_ack}, 32'd1);
   endtask

   task automatic run_tz(input logic [31:0] a, input logic [31:0] exp, input string tag);
      int waitc;
      @(negedge clk);
      waitc = 0;
      while (!t_ack && waitc < 50) begin
         @(negedge clk);
         waitc++;
      end
      t_a   = a;
      t_stb = 1'b1;
      @(negedge clk);
      t_stb = 1'b0;
      waitc = 0;
      while (!t_zstb && waitc < 60) begin
         @(negedge clk);
         waitc++;
      end
      check({tag, " stb"}, {31'd0, t_zstb}, 32'd1);
      check({tag, " result"}, t_z, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b0;
      input_a      = '0;
      input_a_stb  = 1'b0;
      output_z_ack = 1'b0;
      t_a          = '0;
      t_stb        = 1'b0;
      t_zack       = 1'b1;

      #1;
      check("reset out", {output_z_stb, input_a_ack, output_z[29:0]}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("ack after release", {31'd0, input_a_ack}, 32'd1);

      run_op(32'h00000000, 1, 0, "zero");
      check("zero value", exp_q.size() == 0 ? 32'h0 : 32'h1, 32'h0);
      run_op(32'h00000001, 35, 0, "one");
      run_op(32'h80000000, 4, 0, "msb");
      run_op(32'hFFFFFFFF, 4, 0, "carry");
      run_op(32'h01000001, 0, 0, "tie down");
      run_op(32'h01000003, 0, 0, "tie up");
      run_op(32'h01000002, 0, 0, "exact");
      run_op(32'h00FFFFFF, 0, 0, "max exact");
      run_op(32'h12345678, 0, 5, "backpressure");

      run_tz(32'hFFFFFFFF, 32'h4F7FFFFF, "trunc carry");
      run_tz(32'h01000003, 32'h4B800001, "trunc tie");

      for (int i = 0; i < 100; i++) begin
         run_op($urandom >> $urandom_range(0, 31), 0, 0, "random");
      end

      @(negedge clk);
      input_a     = 32'h00000001;
      input_a_stb = 1'b1;
      @(negedge clk);
      input_a_stb = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid reset stb/ack", {30'd0, output_z_stb, input_a_ack}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("ack after mid reset", {31'd0, input_a_ack}, 32'd1);
      run_op(32'h00000007, 33, 0, "seven");
      check("seven direct", ref_float(32'h00000007), 32'h40E00000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
